// File: rtl/tw_gen_if.sv
// -----------------------------------------------------------------------------
// tw_gen_if : bundle between the twiddle-factor generator, its controller,
//             the external quarter-wave sine ROM and the twiddle multiplier.
//
// master : the environment. It drives start/adv and returns ROM data.
// slave  : tw_gen.
//
// Signals
//   start        one-cycle pulse, begins a full FFT sequence
//   adv          request the twiddle for the next butterfly
//   busy         sequence in progress, until the last twiddle has left
//   rom_addr_s/c ROM port A (sin) / port B (cos) addresses
//   rom_data_s/c ROM magnitudes, one cycle after the address
//   sin_theta    sign-magnitude sin
//   cos_theta    sign-magnitude cos
//   tw_val       sin/cos valid (multiplier enable)
//   tw_stage     stage index of the current output
//   tw_last      final twiddle of the sequence, aligned with tw_val
// -----------------------------------------------------------------------------
interface tw_gen_if #(
  parameter int N_LOG2    = 10,
  parameter int ROM_WIDTH = 18,
  parameter int ADDR_W    = N_LOG2 - 1
);
  logic                 start;
  logic                 adv;
  logic                 busy;
  logic [ADDR_W-1:0]    rom_addr_s;
  logic [ADDR_W-1:0]    rom_addr_c;
  logic [ROM_WIDTH-2:0] rom_data_s;
  logic [ROM_WIDTH-2:0] rom_data_c;
  logic [ROM_WIDTH-1:0] sin_theta;
  logic [ROM_WIDTH-1:0] cos_theta;
  logic                 tw_val;
  logic [4:0]           tw_stage;
  logic                 tw_last;

  modport master (
    output start, adv, rom_data_s, rom_data_c,
    input  busy, rom_addr_s, rom_addr_c, sin_theta, cos_theta,
           tw_val, tw_stage, tw_last
  );

  modport slave (
    input  start, adv, rom_data_s, rom_data_c,
    output busy, rom_addr_s, rom_addr_c, sin_theta, cos_theta,
           tw_val, tw_stage, tw_last
  );
endinterface

// File: rtl/tw_gen.sv
// -----------------------------------------------------------------------------
// tw_gen : twiddle-factor generator for a radix-2 DIT FFT.
//
// After start, each accepted adv issues the twiddle for (stage, j), walking
// j = 0..N/2-1 for every stage 0..N_LOG2-1. The twiddle index
//   k = (j & (2^stage-1)) << (N_LOG2-1-stage)
// is folded into a quarter-wave ROM lookup, and the quadrant sign is applied
// to the returned magnitudes. Fixed latency of 3 cycles from adv to tw_val,
// one twiddle per cycle, no backpressure.
//
// Ports
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  tw_gen_if.slave (start/adv in, ROM ports, sin/cos out, status)
// -----------------------------------------------------------------------------
module tw_gen #(
  parameter int N_LOG2    = 10,
  parameter int ROM_WIDTH = 18,
  parameter int ADDR_W    = N_LOG2 - 1
) (
  input  logic     clk,
  input  logic     rst,
  tw_gen_if.slave  bus
);

  localparam logic [ADDR_W-1:0] QUARTER = ADDR_W'(1 << (N_LOG2 - 2));
  localparam logic [4:0]        LAST_ST = 5'(N_LOG2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Issue stage (cycle n -> n+1)
  state_t              r_state;
  logic [4:0]          r_stage;
  logic [N_LOG2-2:0]   r_j;
  logic                r_busy;
  logic                r_v1;
  logic                r_last1;
  logic [1:0]          r_q1;
  logic [4:0]          r_stage1;
  logic [ADDR_W-1:0]   r_addr_s;
  logic [ADDR_W-1:0]   r_addr_c;

  // ROM wait stage (cycle n+1 -> n+2)
  logic                r_v2;
  logic                r_last2;
  logic [1:0]          r_q2;
  logic [4:0]          r_stage2;

  // Output stage (cycle n+3)
  logic                 r_tw_val;
  logic                 r_tw_last;
  logic [4:0]           r_tw_stage;
  logic [ROM_WIDTH-1:0] r_sin;
  logic [ROM_WIDTH-1:0] r_cos;

  logic [N_LOG2-1:0]   w_mask;
  logic [4:0]          w_shamt;
  logic [N_LOG2-1:0]   w_k;
  logic [1:0]          w_q;
  logic [ADDR_W-1:0]   w_r;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_neg_s;
  logic                w_neg_c;

  assign w_mask       = (N_LOG2'(1) << r_stage) - N_LOG2'(1);
  assign w_shamt      = LAST_ST - r_stage;
  assign w_k          = (N_LOG2'(r_j) & w_mask) << w_shamt;
  assign w_q          = w_k[N_LOG2-1 -: 2];
  assign w_r          = ADDR_W'(w_k[N_LOG2-3:0]);
  assign w_issue      = (r_state == S_RUN) && bus.adv;
  assign w_last_issue = (r_stage == LAST_ST) && (&r_j);

  // Quadrant signs: sin < 0 in q2/q3, cos < 0 in q1/q2.
  assign w_neg_s = r_q2[1];
  assign w_neg_c = r_q2[1] ^ r_q2[0];

  // Sequencer and address stage.
  // NOTE: every clocked assignment uses <= so all registers sample the values
  // from before the edge; a blocking = here would let later lines see
  // already-updated state and silently shorten the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_stage  <= '0;
      r_j      <= '0;
      r_busy   <= 1'b0;
      r_v1     <= 1'b0;
      r_last1  <= 1'b0;
      r_q1     <= '0;
      r_stage1 <= '0;
      r_addr_s <= '0;
      r_addr_c <= '0;
    end else begin
      r_v1    <= w_issue;
      r_last1 <= w_issue && w_last_issue;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_stage <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.adv) begin
            r_q1     <= w_q;
            r_stage1 <= r_stage;
            // Even quadrants read sin forward; odd quadrants mirror it.
            r_addr_s <= w_q[0] ? (QUARTER - w_r) : w_r;
            r_addr_c <= w_q[0] ? w_r : (QUARTER - w_r);
            r_j      <= r_j + 1'b1;
            if (&r_j) begin
              r_stage <= r_stage + 5'd1;
            end
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last twiddle is on the outputs this cycle: pipeline empties.
          if (r_tw_val && r_tw_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ROM wait stage and signed output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2       <= 1'b0;
      r_last2    <= 1'b0;
      r_q2       <= '0;
      r_stage2   <= '0;
      r_tw_val   <= 1'b0;
      r_tw_last  <= 1'b0;
      r_tw_stage <= '0;
      r_sin      <= '0;
      r_cos      <= '0;
    end else begin
      r_v2      <= r_v1;
      r_last2   <= r_last1;
      r_tw_val  <= r_v2;
      r_tw_last <= r_v2 && r_last2;
      if (r_v1) begin
        r_q2     <= r_q1;
        r_stage2 <= r_stage1;
      end
      // sin/cos hold their last value between valid outputs.
      if (r_v2) begin
        r_tw_stage <= r_stage2;
        // A zero magnitude never carries a sign.
        r_sin <= {w_neg_s && (|bus.rom_data_s), bus.rom_data_s};
        r_cos <= {w_neg_c && (|bus.rom_data_c), bus.rom_data_c};
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.rom_addr_s = r_addr_s;
  assign bus.rom_addr_c = r_addr_c;
  assign bus.sin_theta  = r_sin;
  assign bus.cos_theta  = r_cos;
  assign bus.tw_val     = r_tw_val;
  assign bus.tw_stage   = r_tw_stage;
  assign bus.tw_last    = r_tw_last;

endmodule

// File: tb/tb_tw_gen.sv
// -----------------------------------------------------------------------------
// tb_tw_gen : self-checking bench for tw_gen (N = 8, 18-bit coefficients).
// A 1-cycle-read ROM model serves the DUT. The reference model derives each
// expected twiddle from its issue number and the trig identities
// sin(x+pi) = -sin(x), cos(x) = sin(x+pi/2) over the quarter-wave table.
// -----------------------------------------------------------------------------
module tb_tw_gen;
  localparam int N_LOG2    = 3;
  localparam int ROM_WIDTH = 18;
  localparam int ADDR_W    = N_LOG2 - 1;
  localparam int N         = 1 << N_LOG2;
  localparam int NH        = N / 2;
  localparam int NQ        = N / 4;
  localparam int TOTAL     = NH * N_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tw_gen_if #(.N_LOG2(N_LOG2), .ROM_WIDTH(ROM_WIDTH), .ADDR_W(ADDR_W)) bus ();

  tw_gen #(.N_LOG2(N_LOG2), .ROM_WIDTH(ROM_WIDTH), .ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Quarter-wave sine ROM, registered read.
  logic [ROM_WIDTH-2:0] rom [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
    rom[0] = 17'd0;
    rom[1] = 17'd92682;
    rom[2] = 17'd131071;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rom_data_s <= '0;
      bus.rom_data_c <= '0;
    end else begin
      bus.rom_data_s <= rom[bus.rom_addr_s];
      bus.rom_data_c <= rom[bus.rom_addr_c];
    end
  end

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    int                   due;
    logic [ROM_WIDTH-1:0] s;
    logic [ROM_WIDTH-1:0] c;
    int                   stage;
    bit                   last;
  } tw_t;

  tw_t                  exp_q[$];
  int                   m_start = -1;   // first busy cycle of current sequence
  int                   m_end   = -1;   // last busy cycle, once known
  int                   m_idx   = TOTAL;
  logic [ROM_WIDTH-1:0] e_sin = '0;
  logic [ROM_WIDTH-1:0] e_cos = '0;

  function automatic logic [ROM_WIDTH-1:0] sin_of(input int k);
    int kk, m;
    logic [ROM_WIDTH-2:0] mag;
    kk  = k % N;
    m   = kk % NH;
    mag = rom[(m <= NQ) ? m : NH - m];
    return {(kk >= NH) && (mag != 0), mag};
  endfunction

  function automatic logic [ROM_WIDTH-1:0] cos_of(input int k);
    return sin_of(k + NQ);
  endfunction

  function automatic bit exp_busy(input int t);
    return (m_start >= 0) && (t >= m_start) && ((m_end < 0) || (t <= m_end));
  endfunction

  task automatic check_cycle();
    bit  ev;
    tw_t e;
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("tw_val", bus.tw_val, ev);
    check("busy", bus.busy, exp_busy(cyc));
    if (ev) begin
      e     = exp_q.pop_front();
      e_sin = e.s;
      e_cos = e.c;
      check("tw_stage", bus.tw_stage, e.stage);
      check("tw_last", bus.tw_last, e.last);
    end else begin
      check("tw_last_idle", bus.tw_last, 0);
    end
    check("sin_theta", bus.sin_theta, e_sin);
    check("cos_theta", bus.cos_theta, e_cos);
  endtask

  // Apply one cycle of stimulus (called at a falling edge), update the model,
  // then check the outputs of the following cycle.
  task automatic step(input bit s, input bit a);
    bit  idle, run;
    int  stage, j, k;
    tw_t e;
    bus.start = s;
    bus.adv   = a;
    idle = !exp_busy(cyc);
    run  = exp_busy(cyc) && (m_idx < TOTAL);
    if (idle && s) begin
      m_start = cyc + 1;
      m_end   = -1;
      m_idx   = 0;
    end else if (run && a) begin
      stage   = m_idx / NH;
      j       = m_idx % NH;
      k       = (j % (1 << stage)) * (1 << (N_LOG2 - 1 - stage));
      e.due   = cyc + 3;
      e.s     = sin_of(k);
      e.c     = cos_of(k);
      e.stage = stage;
      e.last  = (m_idx == TOTAL - 1);
      exp_q.push_back(e);
      m_idx++;
      if (m_idx == TOTAL) m_end = cyc + 3;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset(input int hold);
    bus.start = 1'b0;
    bus.adv   = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_tw_val", bus.tw_val, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sin", bus.sin_theta, 0);
    check("rst_cos", bus.cos_theta, 0);
    check("rst_tw_last", bus.tw_last, 0);
    check("rst_tw_stage", bus.tw_stage, 0);
    check("rst_addr_s", bus.rom_addr_s, 0);
    check("rst_addr_c", bus.rom_addr_c, 0);
    exp_q.delete();
    m_start = -1;
    m_end   = -1;
    m_idx   = TOTAL;
    e_sin   = '0;
    e_cos   = '0;
    repeat (hold) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_busy(cyc) || exp_q.size() > 0) && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    bus.start = 1'b0;
    bus.adv   = 1'b0;
    @(negedge clk);
    do_reset(3);
    repeat (3) step(1'b0, 1'b0);

    // Full sequence, adv held high; adv in the start cycle must be ignored.
    step(1'b1, 1'b1);
    repeat (TOTAL) step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);

    // adv toggling with start pulses mid-run, then adv while idle.
    step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step((i % 7) == 3, (i % 2) == 0);
    drain(20);
    repeat (3) step(1'b0, 1'b1);

    // Random traffic: sporadic start pulses, random adv.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    drain(60);

    // Reset after the 5th accepted adv, then a clean full sequence.
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    do_reset(2);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && m_idx < TOTAL; i++)
      step(1'b0, $urandom_range(0, 3) != 0);
    drain(20);
    check("seq_done_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
